lsu_bus_ctrl: RTL and testbench

- Load/store unit between the multicycle CPU datapath's memory-access state and the data-memory bus; it replaces the direct data_memory hookup.
- Accepts one word, halfword or byte access per request and generates byte strobes and lane-replicated write data.
- Handles variable-latency bus acknowledge with a timeout.
- Returns sign- or zero-extended load data plus an error flag for misaligned accesses, illegal funct3 and bus timeouts.

---
 rtl/lsu_bus_ctrl.sv | 104 ++++++++++
 tb/tb_lsu_bus_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store unit bridging the CPU memory-access state to a variable-latency data bus
module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [1:0]  r_state, r_off;
  logic [2:0]  r_f3;
  logic [7:0]  r_cnt;
  logic        r_we, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        w_legal, w_align, w_to;
  logic [31:0] w_wdata, w_sh, w_ext;
  logic [3:0]  w_wstrb;
  assign w_legal = req_we ? (req_funct3 <= 3'd2)
                          : (req_funct3 != 3'd3 && req_funct3 != 3'd6 && req_funct3 != 3'd7);
  assign w_align = req_funct3[1] ? (req_addr[1:0] == 2'b00) : req_funct3[0] ? !req_addr[0] : 1'b1;
  assign w_wdata = req_funct3[1:0] == 2'd0 ? {4{req_wdata[7:0]}} :
                   req_funct3[1:0] == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
  assign w_wstrb = !req_we ? 4'b0000 :
                   req_funct3[1:0] == 2'd0 ? 4'b0001 << req_addr[1:0] :
                   req_funct3[1:0] == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'b1111;
  // Shift the addressed lane down to bit 0, then extend; f3[2] selects the unsigned variants
  assign w_sh  = bus_rdata >> {r_off, 3'b000};
  assign w_ext = r_f3[1:0] == 2'd0 ? {{24{~r_f3[2] & w_sh[7]}}, w_sh[7:0]} :
                 r_f3[1:0] == 2'd1 ? {{16{~r_f3[2] & w_sh[15]}}, w_sh[15:0]} : bus_rdata;
  assign w_to  = r_cnt == TO_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_off   <= '0;
      r_f3    <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (req_valid && w_legal && w_align) begin
            r_state <= S_BUS;
            r_we    <= req_we;
            r_addr  <= {req_addr[31:2], 2'b00};
            r_off   <= req_addr[1:0];
            r_f3    <= req_funct3;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_cnt   <= '0;
          end else if (req_valid) begin
            r_state <= S_RESP;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        S_BUS: begin
          r_cnt <= r_cnt + {7'd0, r_cnt != 8'hff};
          if (bus_ack) begin
            r_state <= S_RESP;
            r_err   <= 1'b0;
            r_rdata <= r_we ? 32'd0 : w_ext;
          end else if (w_to) begin
            r_state <= S_RESP;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign busy       = r_state != S_IDLE;
  assign bus_req    = r_state == S_BUS;
  assign resp_valid = r_state == S_RESP;
  assign resp_err   = r_err;
  assign resp_rdata = r_rdata;
  assign bus_we     = r_we;
  assign bus_addr   = r_addr;
  assign bus_wstrb  = r_wstrb;
  assign bus_wdata  = r_wdata;
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: randomized transaction-level check of lsu_bus_ctrl against a reference model
module tb_lsu_bus_ctrl;
  localparam int TO = 4;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_we = 0, bus_ack = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, bus_rdata = 0;
  logic [2:0]  req_funct3 = 0;
  logic        busy, resp_valid, resp_err, bus_req, bus_we;
  logic [31:0] resp_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  int          n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3), .busy(busy), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int size_of(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic bit legal(input logic we, input logic [2:0] f3);
    return we ? f3 inside {3'd0, 3'd1, 3'd2} : f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * off);
    case (f3)
      3'd0: return (v & 32'hff) >= 128 ? (v & 32'hff) + 32'hffffff00 : v & 32'hff;
      3'd1: return (v & 32'hffff) >= 32768 ? (v & 32'hffff) + 32'hffff0000 : v & 32'hffff;
      3'd4: return v & 32'hff;
      3'd5: return v & 32'hffff;
      default: return d;
    endcase
  endfunction
  task automatic chk_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_breq"}, bus_req, 0);
    check({tag, "_rvalid"}, resp_valid, 0);
    check({tag, "_rerr"}, resp_err, 0);
    check({tag, "_bwe"}, bus_we, 0);
    check({tag, "_wstrb"}, bus_wstrb, 0);
    check({tag, "_baddr"}, bus_addr, 0);
    check({tag, "_bwdata"}, bus_wdata, 0);
    check({tag, "_rdata"}, resp_rdata, 0);
  endtask
  // dly = bus cycle index of bus_ack; dly >= TO means the bus never answers
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3, input int dly, input logic [31:0] rd);
    int sz, off;
    logic [31:0] e_wd;
    logic [3:0] e_strb;
    bit acked;
    sz = size_of(f3);
    off = int'(addr % 4);
    e_wd = sz == 1 ? (wd & 32'hff) * 32'h01010101 : sz == 2 ? (wd & 32'hffff) * 32'h00010001 : wd;
    e_strb = we ? 4'(((1 << sz) - 1) << off) : 4'b0000;
    acked = 0;
    check("pre_busy", busy, 0);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    tick;
    req_valid = 0;
    if (!legal(we, f3) || (addr % sz) != 0) begin
      check("err_breq", bus_req, 0);
      check("err_rvalid", resp_valid, 1);
      check("err_rerr", resp_err, 1);
      check("err_rdata", resp_rdata, 0);
    end else begin
      for (int n = 0; n < TO; n++) begin
        check("bus_req", bus_req, 1);
        check("bus_we", bus_we, we);
        check("bus_addr", bus_addr, addr & 32'hfffffffc);
        check("bus_wstrb", bus_wstrb, e_strb);
        check("bus_wdata", bus_wdata, e_wd);
        check("bus_rvalid", resp_valid, 0);
        bus_rdata = n == dly ? rd : $urandom;
        bus_ack = n == dly;
        if (n == 1) begin
          req_valid = 1; req_we = ~we; req_addr = $urandom; req_funct3 = 3'd2;
        end
        tick;
        bus_ack = 0; req_valid = 0;
        if (n == dly) begin
          acked = 1;
          break;
        end
      end
      check("rsp_breq", bus_req, 0);
      check("rsp_rvalid", resp_valid, 1);
      check("rsp_rerr", resp_err, !acked);
      check("rsp_rdata", resp_rdata, (acked && !we) ? model_load(f3, off, rd) : 32'd0);
    end
    tick;
    check("post_rvalid", resp_valid, 0);
    check("post_busy", busy, 0);
  endtask
  initial begin
    logic [31:0] a;
    logic [2:0] f;
    repeat (3) tick;
    rst = 0;
    chk_reset("rst");
    txn(0, 32'h10, 0, 3'd2, 0, 32'hDEADBEEF);
    txn(0, 32'h13, 0, 3'd0, 1, 32'h80FF0011);
    txn(0, 32'h13, 0, 3'd4, 0, 32'h80FF0011);
    txn(1, 32'h22, 32'h0000ABCD, 3'd1, 3, 32'h0);
    txn(0, 32'h02, 0, 3'd2, 0, 32'h0);
    txn(0, 32'h00, 0, 3'd3, 0, 32'h0);
    txn(0, 32'h40, 0, 3'd2, 9, 32'h12345678);
    req_valid = 1; req_we = 1; req_addr = 32'h104; req_wdata = 32'h55AA55AA; req_funct3 = 3'd2;
    tick;
    req_valid = 0;
    check("mid_breq", bus_req, 1);
    rst = 1;
    tick;
    rst = 0;
    chk_reset("mid_rst");
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    tick;
    bus_ack = 0;
    check("late_ack_rvalid", resp_valid, 0);
    check("late_ack_busy", busy, 0);
    for (int i = 0; i < 300; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f) - 1);
      txn(1'($urandom_range(0, 1)), a, $urandom, f, $urandom_range(0, 5), $urandom);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
